// File: rtl/hdmi_line_reader.sv
// Frame-buffer line fetcher: Avalon-MM burst reads of one video line, streamed out as an Avalon-ST packet.
// Optional HDMI_LINE_READER_PATTERN_EN: synthetic test line generation while the frame buffer is not ready.
module hdmi_line_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned BURST_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_buffer_ready,
  input  logic [ADDR_WIDTH-1:0] frame_base_i,
  input  logic                  line_request_i,
  output logic [ADDR_WIDTH-1:0] avm_address_o,
  output logic                  avm_read_o,
  output logic [7:0]            avm_burstcount_o,
  input  logic                  avm_waitrequest_i,
  input  logic [DATA_WIDTH-1:0] avm_readdata_i,
  input  logic                  avm_readdatavalid_i,
  output logic                  aso_src_valid_o,
  output logic [DATA_WIDTH-1:0] aso_src_data_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES    = BURST_LEN * BYTES_PER_WORD;
  localparam int unsigned LINE_BYTES     = H_ACTIVE * BYTES_PER_WORD;
  localparam int unsigned NUM_BURSTS     = H_ACTIVE / BURST_LEN;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BIDX_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned WCNT_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LCNT_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_FLUSH, ST_PAT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [BIDX_W-1:0]     burst_idx_q, burst_idx_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [LCNT_W-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  last_beat, last_burst, last_word, last_line;
  logic                  adv_line, clr_line;

  assign last_beat  = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
  assign last_burst = (burst_idx_q == BIDX_W'(NUM_BURSTS - 1));
  assign last_word  = (word_cnt_q == WCNT_W'(H_ACTIVE - 1));
  assign last_line  = (line_cnt_q == LCNT_W'(V_ACTIVE - 1));

`ifdef HDMI_LINE_READER_PATTERN_EN
  logic        ready_q;
  logic [31:0] pat_x, pat_l;
  logic [DATA_WIDTH-1:0] pat_word;

  // Line count only restarts when the buffer goes away, so pattern lines can step through a frame.
  assign clr_line = ready_q & ~frame_buffer_ready;
  assign pat_x    = (state_q == ST_PAT) ? 32'(word_cnt_q) : 32'd0;
  assign pat_l    = 32'(line_cnt_q);
  assign pat_word = DATA_WIDTH'({8'h00, pat_x[7:0], pat_x[7:0], pat_l[7:0]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= frame_buffer_ready;
  end
`else
  assign clr_line = ~frame_buffer_ready;
`endif

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    burst_idx_d = burst_idx_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    adv_line    = 1'b0;
    overrun_d   = overrun_q | (line_request_i & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (line_request_i && frame_buffer_ready) begin
          state_d     = ST_CMD;
          burst_idx_d = '0;
          beat_cnt_d  = '0;
          word_cnt_d  = '0;
          if (line_cnt_q == '0) line_addr_d = frame_base_i;
        end
`ifdef HDMI_LINE_READER_PATTERN_EN
        else if (line_request_i) begin
          state_d    = ST_PAT;
          valid_d    = 1'b1;
          data_d     = pat_word;
          sop_d      = 1'b1;
          word_cnt_d = WCNT_W'(1);
        end
`endif
      end
      ST_CMD: begin
        // An accepted command always owes BURST_LEN beats, so a drop here must still drain them.
        if (!avm_waitrequest_i) begin
          state_d    = frame_buffer_ready ? ST_DATA : ST_FLUSH;
          beat_cnt_d = '0;
        end else if (!frame_buffer_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (avm_readdatavalid_i) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (frame_buffer_ready) begin
            valid_d    = 1'b1;
            data_d     = avm_readdata_i;
            sop_d      = (word_cnt_q == '0);
            eop_d      = last_word;
            word_cnt_d = last_word ? '0 : word_cnt_q + WCNT_W'(1);
          end
          if (last_beat) begin
            if (!frame_buffer_ready) begin
              state_d = ST_IDLE;
            end else if (!last_burst) begin
              state_d     = ST_CMD;
              burst_idx_d = burst_idx_q + BIDX_W'(1);
            end else begin
              state_d     = ST_IDLE;
              adv_line    = 1'b1;
              line_addr_d = line_addr_q + ADDR_WIDTH'(LINE_BYTES);
            end
          end else if (!frame_buffer_ready) begin
            state_d = ST_FLUSH;
          end
        end else if (!frame_buffer_ready) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (avm_readdatavalid_i) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (last_beat) state_d = ST_IDLE;
        end
      end
`ifdef HDMI_LINE_READER_PATTERN_EN
      ST_PAT: begin
        valid_d    = 1'b1;
        data_d     = pat_word;
        eop_d      = last_word;
        word_cnt_d = last_word ? '0 : word_cnt_q + WCNT_W'(1);
        if (last_word) begin
          state_d  = ST_IDLE;
          adv_line = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (adv_line) line_cnt_d = last_line ? '0 : line_cnt_q + LCNT_W'(1);
    if (clr_line) line_cnt_d = '0;

    // Address/read are derived from next-state so the command lands the cycle after the request.
    read_d = (state_d == ST_CMD);
    addr_d = read_d ? (line_addr_d + ADDR_WIDTH'(burst_idx_d) * ADDR_WIDTH'(BURST_BYTES)) : addr_q;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      burst_idx_q <= burst_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avm_address_o           = addr_q;
  assign avm_read_o              = read_q;
  assign avm_burstcount_o        = 8'(BURST_LEN);
  assign aso_src_valid_o         = valid_q;
  assign aso_src_data_o          = data_q;
  assign aso_src_startofpacket_o = sop_q;
  assign aso_src_endofpacket_o   = eop_q;
  assign busy_o                  = busy_q;
  assign overrun_o               = overrun_q;

endmodule

// File: tb/tb_hdmi_line_reader.sv
// Scoreboard bench for hdmi_line_reader with a small line geometry and a behavioural Avalon-MM slave.
module tb_hdmi_line_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned H  = 16;
  localparam int unsigned V  = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned NB = H / BL;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  logic          clk, reset_n, frame_buffer_ready, line_request_i;
  logic [AW-1:0] frame_base_i, avm_address_o;
  logic          avm_read_o, avm_waitrequest_i, avm_readdatavalid_i;
  logic [7:0]    avm_burstcount_o;
  logic [DW-1:0] avm_readdata_i, aso_src_data_o;
  logic          aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o;
  logic          busy_o, overrun_o;

  word_t       exp_q[$], got_q[$];
  logic [31:0] exp_cmd_q[$], cmd_q[$], beat_q[$];
  int          got_cyc_q[$], bcyc_q[$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  bit          wait_force = 1'b0, rand_stall = 1'b0;
  int          m_line = 0;
  logic [31:0] m_addr = '0;

  hdmi_line_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .frame_buffer_ready(frame_buffer_ready),
    .frame_base_i(frame_base_i), .line_request_i(line_request_i),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_burstcount_o(avm_burstcount_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
    .avm_readdatavalid_i(avm_readdatavalid_i), .aso_src_valid_o(aso_src_valid_o),
    .aso_src_data_o(aso_src_data_o), .aso_src_startofpacket_o(aso_src_startofpacket_o),
    .aso_src_endofpacket_o(aso_src_endofpacket_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave + output monitor: capture stream words, return BL beats per accepted command (data = ~address).
  initial begin
    avm_waitrequest_i = 1'b0; avm_readdatavalid_i = 1'b0; avm_readdata_i = '0;
  end
  always @(negedge clk) begin
    logic wr;
    if (aso_src_valid_o) begin
      got_q.push_back('{aso_src_data_o, aso_src_startofpacket_o, aso_src_endofpacket_o});
      got_cyc_q.push_back(cyc);
    end
    if (beat_q.size() > 0 && !(rand_stall && $urandom_range(2) == 0)) begin
      avm_readdatavalid_i = 1'b1;
      avm_readdata_i      = beat_q.pop_front();
      bcyc_q.push_back(cyc);
    end else begin
      avm_readdatavalid_i = 1'b0;
    end
    wr = wait_force || (rand_stall && $urandom_range(2) == 0);
    if (avm_read_o && !wr) begin
      cmd_q.push_back(avm_address_o);
      for (int i = 0; i < BL; i++) beat_q.push_back(~(avm_address_o + 32'(4 * i)));
    end
    avm_waitrequest_i = wr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic pulse_req();
    line_request_i = 1'b1;
    step();
    line_request_i = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); exp_cmd_q.delete(); cmd_q.delete();
    got_cyc_q.delete(); bcyc_q.delete();
  endtask

  // Reference model of one full line: expected commands and words.
  task automatic push_line();
    if (m_line == 0) m_addr = frame_base_i;
    for (int k = 0; k < NB; k++) exp_cmd_q.push_back(m_addr + 32'(k * BL * 4));
    for (int w = 0; w < H; w++) exp_q.push_back('{~(m_addr + 32'(4 * w)), w == 0, w == H - 1});
    m_line = (m_line == V - 1) ? 0 : m_line + 1;
    m_addr = m_addr + 32'(H * 4);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    step();
    while (busy_o && n < 2000) begin step(); n++; end
    if (busy_o) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout busy_o still %b after %0d cycles, want 0", tag, busy_o, n);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_buffer_ready = 1'b0; line_request_i = 1'b0; frame_base_i = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    n_cmp++; if (avm_read_o !== 1'b0) begin n_err++; $display("FAIL rst_read got %b want 0", avm_read_o); end
    n_cmp++; if (avm_address_o !== '0) begin n_err++; $display("FAIL rst_addr got %h want 0", avm_address_o); end
    n_cmp++; if (avm_burstcount_o !== 8'(BL)) begin n_err++; $display("FAIL rst_burstcount got %0d want %0d", avm_burstcount_o, BL); end
    n_cmp++; if ({aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o} !== 3'b000) begin
      n_err++; $display("FAIL rst_stream got %b%b%b want 000", aso_src_valid_o, aso_src_startofpacket_o, aso_src_endofpacket_o); end
    n_cmp++; if (aso_src_data_o !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", aso_src_data_o); end
    n_cmp++; if ({busy_o, overrun_o} !== 2'b00) begin n_err++; $display("FAIL rst_status got %b%b want 00", busy_o, overrun_o); end
    m_line = 0;
  endtask

  task automatic test_single_line();
    word_t g, e;
    int gc, bc;
    clear_q();
    frame_buffer_ready = 1'b1; frame_base_i = 32'h1000_0000; rand_stall = 1'b0;
    step();
    push_line();
    pulse_req();
    n_cmp++; if (avm_read_o !== 1'b1 || avm_address_o !== 32'h1000_0000) begin
      n_err++; $display("FAIL single_first_cmd got %b@%h want 1@10000000", avm_read_o, avm_address_o); end
    wait_idle("single");
    n_cmp++; if (cmd_q.size() != exp_cmd_q.size()) begin
      n_err++; $display("FAIL single_cmd_count got %0d want %0d", cmd_q.size(), exp_cmd_q.size()); end
    while (cmd_q.size() > 0 && exp_cmd_q.size() > 0) begin
      n_cmp++; if (cmd_q[0] !== exp_cmd_q[0]) begin n_err++; $display("FAIL single_cmd_addr got %h want %h", cmd_q[0], exp_cmd_q[0]); end
      void'(cmd_q.pop_front()); void'(exp_cmd_q.pop_front());
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_word_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL single_word got %h sop%b eop%b want %h sop%b eop%b", g.data, g.sop, g.eop, e.data, e.sop, e.eop); end
    end
    while (got_cyc_q.size() > 0 && bcyc_q.size() > 0) begin
      gc = got_cyc_q.pop_front(); bc = bcyc_q.pop_front();
      n_cmp++; if (gc != bc + 1) begin n_err++; $display("FAIL single_latency got cycle %0d want %0d", gc, bc + 1); end
    end
  endtask

  task automatic test_frame_wrap();
    word_t g, e;
    clear_q();
    rand_stall = 1'b1;
    while (m_line != 0) begin push_line(); pulse_req(); wait_idle("wrap"); end
    frame_base_i = 32'h2000_0000;
    push_line(); pulse_req(); wait_idle("wrap_new");
    n_cmp++; if (cmd_q.size() != exp_cmd_q.size()) begin
      n_err++; $display("FAIL wrap_cmd_count got %0d want %0d", cmd_q.size(), exp_cmd_q.size()); end
    else begin
      n_cmp++; if (cmd_q[cmd_q.size() - NB] !== 32'h2000_0000) begin
        n_err++; $display("FAIL wrap_new_base got %h want 20000000", cmd_q[cmd_q.size() - NB]); end
    end
    while (cmd_q.size() > 0 && exp_cmd_q.size() > 0) begin
      n_cmp++; if (cmd_q[0] !== exp_cmd_q[0]) begin n_err++; $display("FAIL wrap_cmd_addr got %h want %h", cmd_q[0], exp_cmd_q[0]); end
      void'(cmd_q.pop_front()); void'(exp_cmd_q.pop_front());
    end
    n_cmp++; if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL wrap_word_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL wrap_word got %h sop%b eop%b want %h sop%b eop%b", g.data, g.sop, g.eop, e.data, e.sop, e.eop); end
    end
    rand_stall = 1'b0;
  endtask

  task automatic test_waitrequest();
    logic [31:0] a0;
    clear_q();
    wait_force = 1'b1;
    push_line();
    a0 = exp_cmd_q[0];
    pulse_req();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (avm_read_o !== 1'b1 || avm_address_o !== a0 || cmd_q.size() != 0) begin
        n_err++; $display("FAIL wait_hold cycle %0d got read %b addr %h cmds %0d want 1 %h 0", i, avm_read_o, avm_address_o, cmd_q.size(), a0); end
      step();
    end
    wait_force = 1'b0;
    wait_idle("wait");
    n_cmp++; if (cmd_q.size() != NB) begin n_err++; $display("FAIL wait_cmd_count got %0d want %0d", cmd_q.size(), NB); end
    while (cmd_q.size() > 0 && exp_cmd_q.size() > 0) begin
      n_cmp++; if (cmd_q[0] !== exp_cmd_q[0]) begin n_err++; $display("FAIL wait_cmd_addr got %h want %h", cmd_q[0], exp_cmd_q[0]); end
      void'(cmd_q.pop_front()); void'(exp_cmd_q.pop_front());
    end
    n_cmp++; if (got_q.size() != H) begin n_err++; $display("FAIL wait_word_count got %0d want %0d", got_q.size(), H); end
  endtask

  task automatic test_overrun();
    word_t g, e;
    clear_q();
    push_line();
    pulse_req();
    repeat (4) step();
    pulse_req();
    n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL overrun_set got %b want 1", overrun_o); end
    wait_idle("overrun");
    n_cmp++; if (got_q.size() != H) begin n_err++; $display("FAIL overrun_word_count got %0d want %0d", got_q.size(), H); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL overrun_word got %h sop%b eop%b want %h sop%b eop%b", g.data, g.sop, g.eop, e.data, e.sop, e.eop); end
    end
    clear_q();
    push_line(); pulse_req(); wait_idle("overrun2");
    n_cmp++; if (got_q.size() != H || overrun_o !== 1'b1) begin
      n_err++; $display("FAIL overrun_sticky got words %0d overrun %b want %0d 1", got_q.size(), overrun_o, H); end
  endtask

  task automatic test_ready_drop();
    word_t g, e;
    int n = 0;
    clear_q();
    if (m_line == 0) begin push_line(); pulse_req(); wait_idle("drop_pre"); clear_q(); end
    frame_base_i = 32'h3000_0000;
    for (int w = 0; w < 5; w++) exp_q.push_back('{~(m_addr + 32'(4 * w)), w == 0, 1'b0});
    pulse_req();
    while (got_q.size() < 5 && n < 500) begin step(); n++; end
    frame_buffer_ready = 1'b0;
    wait_idle("drop");
    n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL drop_word_count got %0d want 5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL drop_word got %h sop%b eop%b want %h sop%b eop%b", g.data, g.sop, g.eop, e.data, e.sop, e.eop); end
    end
    n_cmp++; if (beat_q.size() != 0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL drop_idle got pending %0d busy %b want 0 0", beat_q.size(), busy_o); end
    m_line = 0;
`ifndef HDMI_LINE_READER_PATTERN_EN
    clear_q();
    pulse_req();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL notready_busy got %b want 0", busy_o); end
    repeat (4) step();
    n_cmp++; if (got_q.size() != 0 || cmd_q.size() != 0) begin
      n_err++; $display("FAIL notready_traffic got words %0d cmds %0d want 0 0", got_q.size(), cmd_q.size()); end
`endif
    clear_q();
    frame_buffer_ready = 1'b1;
    step();
    push_line(); pulse_req(); wait_idle("drop_after");
    n_cmp++; if (cmd_q.size() == 0 || cmd_q[0] !== 32'h3000_0000) begin
      n_err++; $display("FAIL drop_line0_base got %h want 30000000", (cmd_q.size() > 0) ? cmd_q[0] : 32'hx); end
    n_cmp++; if (got_q.size() != H) begin n_err++; $display("FAIL drop_after_count got %0d want %0d", got_q.size(), H); end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_q();
    pulse_req();
    while (got_q.size() < 2 && n < 500) begin step(); n++; end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_cmp++; if ({busy_o, avm_read_o, aso_src_valid_o, overrun_o} !== 4'b0000) begin
      n_err++; $display("FAIL midrst_clear got busy%b read%b valid%b ovr%b want 0000", busy_o, avm_read_o, aso_src_valid_o, overrun_o); end
    repeat (8) step();
    n_cmp++; if (got_q.size() != 2 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_ignore got words %0d busy %b want 2 0", got_q.size(), busy_o); end
    clear_q();
    m_line = 0;
    frame_base_i = 32'h4000_0000;
    push_line(); pulse_req(); wait_idle("midrst_after");
    n_cmp++; if (cmd_q.size() == 0 || cmd_q[0] !== 32'h4000_0000) begin
      n_err++; $display("FAIL midrst_base got %h want 40000000", (cmd_q.size() > 0) ? cmd_q[0] : 32'hx); end
    n_cmp++; if (got_q.size() != H) begin n_err++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), H); end
  endtask

`ifdef HDMI_LINE_READER_PATTERN_EN
  task automatic test_pattern();
    word_t g, e;
    logic [7:0] wb, lb;
    clear_q();
    frame_buffer_ready = 1'b0;
    repeat (3) step();
    for (int l = 0; l < V; l++) begin
      lb = 8'(l);
      for (int w = 0; w < H; w++) begin
        wb = 8'(w);
        exp_q.push_back('{{8'h00, wb, wb, lb}, w == 0, w == H - 1});
      end
      pulse_req();
      if (l == 0) begin
        n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL pat_first_latency got %0d words want 1", got_q.size()); end
      end
      wait_idle("pattern");
    end
    n_cmp++; if (got_q.size() != V * H) begin n_err++; $display("FAIL pat_count got %0d want %0d", got_q.size(), V * H); end
    else begin
      n_cmp++; if (got_q[3 * H + 5].data !== 32'h0005_0503) begin
        n_err++; $display("FAIL pat_word5_line3 got %h want 00050503", got_q[3 * H + 5].data); end
    end
    n_cmp++; if (cmd_q.size() != 0) begin n_err++; $display("FAIL pat_cmds got %0d want 0", cmd_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL pat_word got %h sop%b eop%b want %h sop%b eop%b", g.data, g.sop, g.eop, e.data, e.sop, e.eop); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_frame_wrap();
    test_waitrequest();
    test_overrun();
    test_ready_drop();
    test_reset_mid_burst();
`ifdef HDMI_LINE_READER_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
